// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
//   RF_A_WIDTH / RF_D_WIDTH : default register address / data widths
//   RF_BUF_DEPTH            : default multi-cycle result buffer depth
//   RF_STARVE_MAX           : default blocked-cycle limit before a forced drain
//   wb_req_t                : one writeback request (valid, killed, ad, wd)
//   arb_state_t             : arbiter FSM states
package rf_pkg;

  localparam int RF_A_WIDTH    = 5;
  localparam int RF_D_WIDTH    = 32;
  localparam int RF_BUF_DEPTH  = 2;
  localparam int RF_STARVE_MAX = 4;

  typedef struct packed {
    logic                  valid;
    logic                  killed;
    logic [RF_A_WIDTH-1:0] ad;
    logic [RF_D_WIDTH-1:0] wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for multi-cycle writeback results.
// Entries carry a kill flag: a kill request marks every occupied entry whose
// address matches; killed entries keep their slot until popped.
//   clk, rst          : clock, asynchronous active-high reset
//   push/push_ad/wd   : enqueue at tail (caller guarantees !full)
//   pop               : retire head (caller guarantees !empty)
//   kill_en/kill_ad   : mark occupied entries with address kill_ad as killed
//   full, empty, count: occupancy
//   head_killed/ad/wd : head entry view
//   ent_live, ent_ad  : per-slot live flag (occupied and not killed) and address
module wb_fifo #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [A_WIDTH-1:0]                push_ad,
  input  logic [D_WIDTH-1:0]                push_wd,
  input  logic                              pop,
  input  logic                              kill_en,
  input  logic [A_WIDTH-1:0]                kill_ad,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              head_killed,
  output logic [A_WIDTH-1:0]                head_ad,
  output logic [D_WIDTH-1:0]                head_wd,
  output logic [DEPTH-1:0]                  ent_live,
  output logic [DEPTH-1:0][A_WIDTH-1:0]     ent_ad
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]      head, tail;
  logic [DEPTH-1:0]   occ_q, kill_q;
  logic [A_WIDTH-1:0] ad_q [DEPTH];
  logic [D_WIDTH-1:0] wd_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      occ_q  <= '0;
      kill_q <= '0;
    end else begin
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (occ_q[i] && ad_q[i] == kill_ad) kill_q[i] <= 1'b1;
        end
      end
      if (pop) begin
        occ_q[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      // The tail slot is never occupied when pushing, so this cannot race the kill loop.
      if (push) begin
        occ_q[tail]  <= 1'b1;
        kill_q[tail] <= 1'b0;
        tail         <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ad_q[tail] <= push_ad;
      wd_q[tail] <= push_wd;
    end
  end

  always_comb begin
    full        = (count == CW'(DEPTH));
    empty       = (count == '0);
    head_killed = kill_q[head];
    head_ad     = ad_q[head];
    head_wd     = wd_q[head];
    for (int i = 0; i < DEPTH; i++) begin
      ent_live[i] = occ_q[i] & ~kill_q[i];
      ent_ad[i]   = ad_q[i];
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the pipeline writeback (priority,
// no backpressure) and a multi-cycle unit (valid/ready). Multi-cycle results
// that cannot be written immediately are buffered; a pipeline write kills
// older buffered results to the same register. If the buffer head is blocked
// STARVE_MAX consecutive cycles, stall_req is raised for one cycle to force a drain.
//   clk, rst                : clock, asynchronous active-high reset
//   p_we, p_ad, p_wd        : pipeline writeback
//   m_valid/m_ready/m_ad/wd : multi-cycle result handshake
//   we3, ad3, wd3           : register file write port
//   pend_mask               : registers with a live buffered write outstanding
//   stall_req               : hold the pipeline writeback slot this cycle
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int A_WIDTH    = RF_A_WIDTH,
  parameter int D_WIDTH    = RF_D_WIDTH,
  parameter int BUF_DEPTH  = RF_BUF_DEPTH,
  parameter int STARVE_MAX = RF_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_we,
  input  logic [A_WIDTH-1:0]    p_ad,
  input  logic [D_WIDTH-1:0]    p_wd,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic [A_WIDTH-1:0]    m_ad,
  input  logic [D_WIDTH-1:0]    m_wd,
  output logic                  we3,
  output logic [A_WIDTH-1:0]    ad3,
  output logic [D_WIDTH-1:0]    wd3,
  output logic [2**A_WIDTH-1:0] pend_mask,
  output logic                  stall_req
);

  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);

  arb_state_t state, state_d;
  logic [SW-1:0] cnt, cnt_d;

  logic full, empty, head_killed;
  logic [CW-1:0] count;
  logic [A_WIDTH-1:0] head_ad;
  logic [D_WIDTH-1:0] head_wd;
  logic [BUF_DEPTH-1:0] ent_live;
  logic [BUF_DEPTH-1:0][A_WIDTH-1:0] ent_ad;

  logic p_hit, m_live, drain, direct, enq;

  assign stall_req = (state == FORCE);
  assign m_ready   = !rst && !full;
  assign m_live    = m_valid && m_ready && (m_ad != '0);
  // A pipeline write seen during a forced drain is dropped.
  assign p_hit     = !rst && p_we && (p_ad != '0) && !stall_req;

  always_comb begin
    we3    = 1'b0;
    ad3    = '0;
    wd3    = '0;
    drain  = 1'b0;
    direct = 1'b0;
    if (!rst) begin
      if (!empty && (stall_req || !p_hit)) begin
        drain = 1'b1;
        if (!head_killed) begin
          we3 = 1'b1;
          ad3 = head_ad;
          wd3 = head_wd;
        end
      end else if (p_hit) begin
        we3 = 1'b1;
        ad3 = p_ad;
        wd3 = p_wd;
      end else if (m_live && empty) begin
        direct = 1'b1;
        we3    = 1'b1;
        ad3    = m_ad;
        wd3    = m_wd;
      end
    end
  end

  // A concurrent accept to the register the pipeline is writing is already stale.
  assign enq = m_live && !direct && !(p_hit && m_ad == p_ad);

  wb_fifo #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH),
    .DEPTH   (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (enq),
    .push_ad     (m_ad),
    .push_wd     (m_wd),
    .pop         (drain),
    .kill_en     (p_hit),
    .kill_ad     (p_ad),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .head_killed (head_killed),
    .head_ad     (head_ad),
    .head_wd     (head_wd),
    .ent_live    (ent_live),
    .ent_ad      (ent_ad)
  );

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (ent_live[i]) pend_mask[ent_ad[i]] = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (enq) state_d = PEND;
      end
      PEND: begin
        if (drain) begin
          cnt_d = '0;
          if (count == CW'(1) && !enq) state_d = IDLE;
        end else if (p_hit) begin
          if (cnt == SW'(STARVE_MAX-1)) begin
            state_d = FORCE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + SW'(1);
          end
        end
      end
      FORCE: begin
        cnt_d   = '0;
        state_d = (count == CW'(1) && !enq) ? IDLE : PEND;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Upstream must hold p_we low while stall_req is high.
  a_no_pwe_in_force: assert property (@(posedge clk) disable iff (rst) !(stall_req && p_we))
    else $error("p_we asserted while stall_req is high");

endmodule
